sdwr_serializer: RTL

Bus-write-driven serial transmitter for the serial-data window, the counterpart of the existing bus-read sequencer that returns serial data on SDRD. The CPU has no data path into the window, so it writes a byte as two address-encoded nibbles on BA7..BA4. The block frames the byte and shifts it out on a serial data/clock pair. Status is returned on a read of the same window.

---
 rtl/sdwr_pkg.sv | 22 ++
 rtl/sdwr_bitclk.sv | 41 ++++
 rtl/sdwr_serializer.sv | 110 +++++++++++
 3 files changed

// File: rtl/sdwr_pkg.sv
// sdwr_pkg: shared types, constants and helpers for the serial-data window transmitter.
//   sdwr_state_t    frame FSM states
//   SDWR_FRAME_BITS bits per frame (start + 8 data + parity + stop)
//   WIN_BA13/12     address decode values that select the window
//   parity8         even-parity bit of a byte
package sdwr_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } sdwr_state_t;

    localparam int SDWR_FRAME_BITS = 11;
    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/sdwr_bitclk.sv
// sdwr_bitclk: half-period divider producing the serial clock and bit-phase pulses.
//   clk, rst_n  system clock, async active-low reset
//   en          run while a frame is active; held cleared otherwise
//   bit_start   first clock of a bit
//   half_tick   last clock of either half period
//   high        current clock lies in the second (sclk high) half
//   sclk_o      registered serial clock, idles high
module sdwr_bitclk #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_start,
    output logic half_tick,
    output logic high,
    output logic sclk_o
);
    logic [7:0] cnt;

    assign half_tick = en & (cnt == 8'(DIV - 1));
    assign bit_start = en & (cnt == 8'd0) & ~high;

    // sclk_o mirrors the phase of the previous clock, matching the one-clock
    // registered lag of sdwr and busy in the top level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            high   <= 1'b0;
            sclk_o <= 1'b1;
        end else if (!en) begin
            cnt    <= '0;
            high   <= 1'b0;
            sclk_o <= 1'b1;
        end else begin
            cnt    <= half_tick ? 8'd0 : cnt + 8'd1;
            high   <= high ^ half_tick;
            sclk_o <= high;
        end
    end
endmodule

// File: rtl/sdwr_serializer.sv
// sdwr_serializer: assembles a byte from two address-encoded nibble writes and sends it as a framed serial stream.
//   clk, rst_n          system clock, async active-low reset
//   sser, ba13, ba12    window select/decode (window when sser=0, ba13=0, ba12=1)
//   ba                  nibble value on a write
//   br_w, bus_stb       bus direction (1=read) and one-clock valid strobe
//   sdwr, sclk_o        serial data and clock, both idle high
//   busy, nib_pend, ovr frame active, high nibble held, sticky overrun
module sdwr_serializer
    import sdwr_pkg::*;
#(
    parameter int DIV        = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sser,
    input  logic       ba13,
    input  logic       ba12,
    input  logic [3:0] ba,
    input  logic       br_w,
    input  logic       bus_stb,
    output logic       sdwr,
    output logic       sclk_o,
    output logic       busy,
    output logic       nib_pend,
    output logic       ovr
);
    sdwr_state_t state, state_nx;
    logic       win, wr_hit, rd_hit, start, en;
    logic       bit_start, half_tick, high, bit_end, sdwr_nx, par;
    logic [3:0] held;
    logic [7:0] sh;
    logic [2:0] bcnt;

    assign win     = bus_stb & ~sser & (ba13 == WIN_BA13) & (ba12 == WIN_BA12);
    assign wr_hit  = win & ~br_w;
    assign rd_hit  = win & br_w;
    // busy lags the FSM by a clock, so the clock after a start is the only
    // busy=0 clock with the FSM active; nib_pend is always 0 there.
    assign start   = wr_hit & ~busy & nib_pend;
    assign en      = state != S_IDLE;
    assign bit_end = half_tick & high;

    sdwr_bitclk #(.DIV(DIV)) u_bitclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bit_start(bit_start),
        .half_tick(half_tick),
        .high     (high),
        .sclk_o   (sclk_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sdwr_nx  = 1'b1;
        case (state)
            S_IDLE:   state_nx = start ? S_START : S_IDLE;
            S_START:  begin
                sdwr_nx  = 1'b0;
                state_nx = bit_end ? S_DATA : S_START;
            end
            S_DATA:   begin
                sdwr_nx  = sh[0];
                state_nx = (bit_end && bcnt == 3'd7) ? S_PARITY : S_DATA;
            end
            S_PARITY: begin
                sdwr_nx  = par;
                state_nx = bit_end ? S_STOP : S_PARITY;
            end
            S_STOP:   state_nx = bit_end ? S_IDLE : S_STOP;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdwr     <= 1'b1;
            busy     <= 1'b0;
            nib_pend <= 1'b0;
            ovr      <= 1'b0;
            held     <= '0;
            sh       <= '0;
            bcnt     <= '0;
            par      <= 1'b0;
        end else begin
            busy <= en;
            sdwr <= !en ? 1'b1 : bit_start ? sdwr_nx : sdwr;
            if (wr_hit && busy) ovr <= 1'b1;
            else if (rd_hit)    ovr <= 1'b0;
            if (wr_hit && !busy) begin
                nib_pend <= ~nib_pend;
                if (!nib_pend) held <= ba;
            end
            if (start) begin
                sh   <= {held, ba};
                par  <= parity8({held, ba}) ^ PARITY_ODD;
                bcnt <= '0;
            end else if (state == S_DATA && bit_end) begin
                sh   <= sh >> 1;
                bcnt <= bcnt + 3'd1;
            end
        end
    end
endmodule
